pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Holds the architectural PC register and performs the instruction-fetch stage of the multi-cycle CPU.
- Loads the next-PC value computed by the next-PC block when the controller commits it.
- Fetches the instruction at PC over a req/ack instruction-memory handshake and latches it into IR.
- Its pc output feeds the next-PC block's pc input and the instruction memory address.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles in FETCH without imem_ack before abort (legal range 2..65535).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- npc  input  32  next PC from the next-PC block.
- pc_write  input  1  controller strobe: load npc into PC.
- fetch_start  input  1  controller strobe: fetch instruction at PC.
- imem_ack  input  1  instruction memory: rdata valid this cycle.
- imem_rdata  input  32  instruction memory read data.
- err_clr  input  1  clears sticky error flags.
- pc  output  32  current PC register.
- instr_pc  output  32  address of the instruction currently held in ir.
- ir  output  32  instruction register.
- ir_valid  output  1  one-cycle pulse: ir updated.
- imem_req  output  1  read request, held until ack or abort.
- imem_addr  output  32  read address, equals the PC captured at fetch start.
- busy  output  1  high while in FETCH.
- misalign  output  1  sticky: fetch requested with pc[1:0] != 0.
- fetch_err  output  1  sticky: fetch aborted by timeout.

Behaviour:
- Reset, applied while rst is high at a clk edge and overriding any in-flight fetch:
  - pc = RESET_PC; instr_pc = RESET_PC; ir = 0.
  - ir_valid, imem_req, busy, misalign and fetch_err = 0; imem_addr = RESET_PC.
  - FSM = IDLE; pending-PC register cleared; timeout counter = 0.
- FSM states: IDLE, FETCH.
- IDLE:
  - pc_write alone: pc <= npc, next cycle.
  - fetch_start with effective PC aligned: effective PC is npc if pc_write is asserted the same cycle, else pc. Then imem_addr <= effective PC, imem_req <= 1, busy <= 1, counter <= 0, go to FETCH. The first req cycle is the cycle after the strobe.
  - fetch_start with effective PC misaligned: misalign <= 1, no request, stay in IDLE, ir/ir_valid unchanged. The pc_write, if present, still takes effect.
- FETCH:
  - imem_req stays high and imem_addr stays stable until exit.
  - imem_ack high: ir <= imem_rdata, instr_pc <= imem_addr, ir_valid pulses high for exactly the next cycle. imem_req and busy drop, go to IDLE.
  - Latency: with ack in the first req cycle, ir_valid is high 2 cycles after fetch_start.
  - No ack and counter == TIMEOUT-1: drop imem_req and busy, fetch_err <= 1, ir unchanged, no ir_valid, go to IDLE. Otherwise counter += 1.
  - fetch_start is ignored.
  - pc_write: npc is stored in the pending register; the last write wins. On exit from FETCH (ack or abort), pc <= pending value in the same edge as the exit.
  - pc_write in the same cycle as ack: that npc is used as the pending value.
- pc never changes except through reset, pc_write, or a pending apply. No wrap-around checks; pc is a plain 32-bit register.
- err_clr clears misalign and fetch_err next cycle. A new error event in the same cycle has priority: the flag stays set.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then fetch:
  - rst 1 cycle, RESET_PC=0x0, then fetch_start; imem_ack=1 with rdata=0x00A00093 on the first req cycle.
  - Required: imem_addr=0x0, ir=0x00A00093, instr_pc=0x0, ir_valid high exactly once, 2 cycles after fetch_start.
- Same-cycle load and fetch:
  - pc_write with npc=0x40 and fetch_start in the same cycle.
  - Required: imem_addr=0x40, pc=0x40; after ack, instr_pc=0x40.
- Deferred pc_write:
  - Issue a fetch; hold ack off for 3 cycles; assert pc_write with npc=0x10, then npc=0x14, during FETCH.
  - Required: pc unchanged until ack, then pc=0x14; imem_addr stays stable throughout.
- Timeout:
  - TIMEOUT=4, no ack.
  - Required: imem_req high exactly 4 cycles, then fetch_err=1, busy=0, ir unchanged. err_clr then clears fetch_err.
- Misalignment:
  - pc_write with npc=0x22, then fetch_start.
  - Required: misalign=1, imem_req never asserts, FSM stays in IDLE.
- Reset mid-fetch:
  - rst during FETCH with req high.
  - Required: next cycle imem_req=0, busy=0, pc=RESET_PC; a late imem_ack is ignored.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Bundles the controller, next-PC and instruction-memory signals of the fetch stage.
// The controller/memory side uses the master modport. The fetch unit uses the slave modport.
interface pc_fetch_if;
    logic [31:0] npc;
    logic        pc_write;
    logic        fetch_start;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        err_clr;
    logic [31:0] pc;
    logic [31:0] instr_pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        busy;
    logic        misalign;
    logic        fetch_err;

    modport master (
        output npc, pc_write, fetch_start, imem_ack, imem_rdata, err_clr,
        input  pc, instr_pc, ir, ir_valid, imem_req, imem_addr, busy, misalign, fetch_err
    );

    modport slave (
        input  npc, pc_write, fetch_start, imem_ack, imem_rdata, err_clr,
        output pc, instr_pc, ir, ir_valid, imem_req, imem_addr, busy, misalign, fetch_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and the instruction-fetch stage (req/ack to instruction memory).
// PC writes that arrive during a fetch are deferred and applied on the edge that leaves FETCH.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         rst,
    pc_fetch_if.slave    bus
);
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr_pc;
    logic [31:0]   r_ir;
    logic          r_ir_valid;
    logic          r_req;
    logic [31:0]   r_addr;
    logic          r_busy;
    logic          r_misalign;
    logic          r_fetch_err;
    logic [31:0]   r_pend;
    logic          r_pend_vld;

    logic [31:0]   w_eff_pc;
    logic          w_fetch_ok;
    logic          w_mis_evt;
    logic          w_timeout;
    logic          w_exit;
    logic [31:0]   w_pend_pc;
    logic          w_pend_vld;

    // A same-cycle pc_write redirects both the fetch address and the alignment check.
    assign w_eff_pc   = bus.pc_write ? bus.npc : r_pc;
    assign w_fetch_ok = (r_state == S_IDLE) && bus.fetch_start && (w_eff_pc[1:0] == 2'b00);
    assign w_mis_evt  = (r_state == S_IDLE) && bus.fetch_start && (w_eff_pc[1:0] != 2'b00);
    assign w_timeout  = (r_state == S_FETCH) && !bus.imem_ack && (r_cnt == CNT_LAST);
    assign w_exit     = (r_state == S_FETCH) && (bus.imem_ack || w_timeout);
    assign w_pend_pc  = bus.pc_write ? bus.npc : r_pend;
    assign w_pend_vld = bus.pc_write || r_pend_vld;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pc        <= RESET_PC;
            r_instr_pc  <= RESET_PC;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= RESET_PC;
            r_busy      <= 1'b0;
            r_misalign  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_pend      <= '0;
            r_pend_vld  <= 1'b0;
        end else begin
            r_ir_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.pc_write) r_pc <= bus.npc;
                    if (w_fetch_ok) begin
                        r_addr  <= w_eff_pc;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_exit) begin
                        r_req      <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                        r_pend_vld <= 1'b0;
                        if (w_pend_vld) r_pc <= w_pend_pc;
                        if (bus.imem_ack) begin
                            r_ir       <= bus.imem_rdata;
                            r_instr_pc <= r_addr;
                            r_ir_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (bus.pc_write) begin
                            r_pend     <= bus.npc;
                            r_pend_vld <= 1'b1;
                        end
                    end
                end
            endcase

            // A fresh error event wins over a clear in the same cycle.
            if (w_mis_evt)         r_misalign <= 1'b1;
            else if (bus.err_clr)  r_misalign <= 1'b0;
            if (w_timeout)         r_fetch_err <= 1'b1;
            else if (bus.err_clr)  r_fetch_err <= 1'b0;
        end
    end

    assign bus.pc        = r_pc;
    assign bus.instr_pc  = r_instr_pc;
    assign bus.ir        = r_ir;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_addr;
    assign bus.busy      = r_busy;
    assign bus.misalign  = r_misalign;
    assign bus.fetch_err = r_fetch_err;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios plus randomized traffic, every cycle compared against a transaction-level model.
module tb_pc_fetch_unit;
    localparam int          TO  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    pc_fetch_if bus();

    pc_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr_pc, m_ir, m_addr;
    logic        m_ir_valid, m_req, m_busy, m_mis, m_ferr;
    int          m_waited;
    logic [31:0] m_pend_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [31:0] n, input logic pw,
                                input logic fs, input logic a, input logic [31:0] d,
                                input logic ec);
        logic [31:0] eff;
        logic        mis_evt, to_evt, done;
        if (r) begin
            m_pc = RPC; m_instr_pc = RPC; m_ir = '0; m_addr = RPC;
            m_ir_valid = 0; m_req = 0; m_busy = 0; m_mis = 0; m_ferr = 0;
            m_waited = 0; m_pend_q.delete();
            return;
        end
        mis_evt = 0; to_evt = 0; done = 0;
        m_ir_valid = 0;
        if (!m_busy) begin
            eff = pw ? n : m_pc;
            if (pw) m_pc = n;
            if (fs) begin
                if (eff % 4 != 0) mis_evt = 1;
                else begin
                    m_addr = eff; m_req = 1; m_busy = 1; m_waited = 0;
                end
            end
        end else begin
            if (pw) m_pend_q.push_back(n);
            if (a) begin
                m_ir = d; m_instr_pc = m_addr; m_ir_valid = 1; done = 1;
            end else if (m_waited + 1 == TO) begin
                to_evt = 1; done = 1;
            end else m_waited++;
            if (done) begin
                m_req = 0; m_busy = 0;
                if (m_pend_q.size() > 0) m_pc = m_pend_q[$];
                m_pend_q.delete();
            end
        end
        if (ec) begin m_mis = 0; m_ferr = 0; end
        if (mis_evt) m_mis = 1;
        if (to_evt)  m_ferr = 1;
    endtask

    task automatic compare_all();
        check("pc",        bus.pc,        m_pc);
        check("instr_pc",  bus.instr_pc,  m_instr_pc);
        check("ir",        bus.ir,        m_ir);
        check("ir_valid",  32'(bus.ir_valid),  32'(m_ir_valid));
        check("imem_req",  32'(bus.imem_req),  32'(m_req));
        check("imem_addr", bus.imem_addr, m_addr);
        check("busy",      32'(bus.busy),      32'(m_busy));
        check("misalign",  32'(bus.misalign),  32'(m_mis));
        check("fetch_err", 32'(bus.fetch_err), 32'(m_ferr));
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, compare away from the edge.
    task automatic step(input logic r, input logic [31:0] n, input logic pw, input logic fs,
                        input logic a, input logic [31:0] d, input logic ec);
        rst = r; bus.npc = n; bus.pc_write = pw; bus.fetch_start = fs;
        bus.imem_ack = a; bus.imem_rdata = d; bus.err_clr = ec;
        @(posedge clk);
        model_update(r, n, pw, fs, a, d, ec);
        #1;
        compare_all();
    endtask

    task automatic idle(input logic a = 1'b0, input logic [31:0] d = 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, a, d, 1'b0);
    endtask

    initial begin
        int req_cycles;
        logic [31:0] v;
        rst = 1'b1; bus.npc = '0; bus.pc_write = 0; bus.fetch_start = 0;
        bus.imem_ack = 0; bus.imem_rdata = '0; bus.err_clr = 0;
        #2;

        // Reset, then fetch with ack on the first request cycle
        step(1'b1, 32'h0, 0, 0, 0, 32'h0, 0);
        check("rst_pc", bus.pc, RPC);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        step(1'b0, 32'h0, 0, 1, 0, 32'h0, 0);
        check("t1_addr", bus.imem_addr, 32'h0);
        check("t1_valid_early", 32'(bus.ir_valid), 32'd0);
        idle(1'b1, 32'h00A0_0093);
        check("t1_valid_lat2", 32'(bus.ir_valid), 32'd1);
        check("t1_ir", bus.ir, 32'h00A0_0093);
        check("t1_instr_pc", bus.instr_pc, 32'h0);
        idle();
        check("t1_valid_once", 32'(bus.ir_valid), 32'd0);

        // Same-cycle load and fetch
        step(1'b0, 32'h40, 1, 1, 0, 32'h0, 0);
        check("t2_addr", bus.imem_addr, 32'h40);
        check("t2_pc", bus.pc, 32'h40);
        idle(1'b1, 32'h1234_5678);
        check("t2_instr_pc", bus.instr_pc, 32'h40);

        // Deferred pc_write during FETCH
        step(1'b0, 32'h0, 0, 1, 0, 32'h0, 0);
        step(1'b0, 32'h10, 1, 0, 0, 32'h0, 0);
        check("t3_pc_hold0", bus.pc, 32'h40);
        step(1'b0, 32'h14, 1, 0, 0, 32'h0, 0);
        check("t3_pc_hold1", bus.pc, 32'h40);
        check("t3_addr_hold", bus.imem_addr, 32'h40);
        idle();
        check("t3_pc_hold2", bus.pc, 32'h40);
        idle(1'b1, 32'hDEAD_0003);
        check("t3_pc_applied", bus.pc, 32'h14);
        check("t3_ir", bus.ir, 32'hDEAD_0003);

        // Timeout with no ack
        req_cycles = 0;
        step(1'b0, 32'h0, 0, 1, 0, 32'h0, 0);
        if (bus.imem_req) req_cycles++;
        for (int k = 0; k < 10 && bus.imem_req; k++) begin
            idle();
            if (bus.imem_req) req_cycles++;
        end
        check("t4_req_cycles", 32'(req_cycles), 32'(TO));
        check("t4_fetch_err", 32'(bus.fetch_err), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd0);
        check("t4_ir_kept", bus.ir, 32'hDEAD_0003);
        step(1'b0, 32'h0, 0, 0, 0, 32'h0, 1);
        check("t4_err_clr", 32'(bus.fetch_err), 32'd0);

        // Misaligned fetch
        step(1'b0, 32'h22, 1, 0, 0, 32'h0, 0);
        step(1'b0, 32'h0, 0, 1, 0, 32'h0, 0);
        check("t5_misalign", 32'(bus.misalign), 32'd1);
        check("t5_req", 32'(bus.imem_req), 32'd0);
        idle(1'b1, 32'hFFFF_FFFF);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_no_valid", 32'(bus.ir_valid), 32'd0);
        step(1'b0, 32'h100, 1, 0, 0, 32'h0, 1);
        check("t5_clr", 32'(bus.misalign), 32'd0);

        // Reset mid-fetch, then a late ack
        step(1'b0, 32'h0, 0, 1, 0, 32'h0, 0);
        idle();
        step(1'b1, 32'h0, 0, 0, 0, 32'h0, 0);
        check("t6_req", 32'(bus.imem_req), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_pc", bus.pc, RPC);
        idle(1'b1, 32'hBAD0_BAD0);
        check("t6_late_ack", 32'(bus.ir_valid), 32'd0);
        check("t6_ir", bus.ir, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            v = $urandom;
            if ($urandom_range(7) != 0) v[1:0] = 2'b00;
            step($urandom_range(63) == 0, v, $urandom_range(3) == 0, $urandom_range(2) == 0,
                 $urandom_range(2) == 0, $urandom, $urandom_range(15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
